sc_level_timer: RTL

SC_LEVEL_TIMER -- requirements
Module: sc_level_timer

---
 rtl/sc_level_timer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sc_level_timer.sv
// ---------------------------------------------------------------------------
// sc_level_timer
//
// Periodic tick generator with a level counter, feeding the game's level
// state machine. A down-counter emits a one-cycle TICK every eff(PERIOD)
// clocks while running; every TICKS_PER_LEVEL ticks the level LV advances.
// When LV reaches LV_MAX the timer stops in DONE until reset.
//
// Configuration macro: SC_LEVEL_TIMER_LVUP_EN
//   defined   -> LVUP pulses together with the tick that advances LV
//   undefined -> LVUP port present but tied to 0
//
// Ports
//   SC_LEVEL_TIMER_CLOCK_50     in   clock, rising edge
//   SC_LEVEL_TIMER_RESET_InHigh in   synchronous reset, active high
//   SC_LEVEL_TIMER_START_InLow  in   run request, active low
//   SC_LEVEL_TIMER_PERIOD       in   tick period in clocks (0 behaves as 1)
//   SC_LEVEL_TIMER_LOAD         in   strobe: capture PERIOD into shadow
//   SC_LEVEL_TIMER_TICK         out  one-cycle terminal-count pulse
//   SC_LEVEL_TIMER_LV           out  current level
//   SC_LEVEL_TIMER_LVUP         out  one-cycle pulse on level increment
//   SC_LEVEL_TIMER_STATE        out  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
// ---------------------------------------------------------------------------
module sc_level_timer #(
    parameter int PERIOD_WIDTH    = 32,
    parameter int LV_WIDTH        = 8,
    parameter int TICKS_PER_LEVEL = 16,
    parameter int LV_MAX          = 59
) (
    input  logic                    SC_LEVEL_TIMER_CLOCK_50,
    input  logic                    SC_LEVEL_TIMER_RESET_InHigh,
    input  logic                    SC_LEVEL_TIMER_START_InLow,
    input  logic [PERIOD_WIDTH-1:0] SC_LEVEL_TIMER_PERIOD,
    input  logic                    SC_LEVEL_TIMER_LOAD,
    output logic                    SC_LEVEL_TIMER_TICK,
    output logic [LV_WIDTH-1:0]     SC_LEVEL_TIMER_LV,
    output logic                    SC_LEVEL_TIMER_LVUP,
    output logic [1:0]              SC_LEVEL_TIMER_STATE
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int TC_WIDTH = $clog2(TICKS_PER_LEVEL) + 1;

    state_t                  state;
    logic [PERIOD_WIDTH-1:0] count;
    logic [PERIOD_WIDTH-1:0] shadow;
    logic [TC_WIDTH-1:0]     tick_cnt;
    logic [LV_WIDTH-1:0]     lv;
    logic                    tick;
    logic                    lvup;

    // Count reload value: eff(P)-1, where a period of 0 is treated as 1.
    function automatic logic [PERIOD_WIDTH-1:0] reload_value(input logic [PERIOD_WIDTH-1:0] p);
        return (p == '0) ? '0 : p - 1'b1;
    endfunction

    // A LOAD coinciding with a reload must take effect in that reload, so the
    // reload sources the post-LOAD shadow value.
    logic [PERIOD_WIDTH-1:0] next_shadow;
    logic                    at_zero;
    logic                    last_tick;
    logic                    last_level;

    assign next_shadow = SC_LEVEL_TIMER_LOAD ? SC_LEVEL_TIMER_PERIOD : shadow;
    assign at_zero     = (count == '0);
    assign last_tick   = (tick_cnt == TC_WIDTH'(TICKS_PER_LEVEL - 1));
    assign last_level  = (lv == LV_WIDTH'(LV_MAX - 1));

    always_ff @(posedge SC_LEVEL_TIMER_CLOCK_50) begin
        if (SC_LEVEL_TIMER_RESET_InHigh) begin
            state    <= IDLE;
            count    <= '0;
            tick_cnt <= '0;
            lv       <= '0;
            tick     <= 1'b0;
            lvup     <= 1'b0;
            shadow   <= SC_LEVEL_TIMER_PERIOD;
        end else begin
            tick   <= 1'b0;
            lvup   <= 1'b0;
            shadow <= next_shadow;
            case (state)
                IDLE: begin
                    if (!SC_LEVEL_TIMER_START_InLow) begin
                        state    <= RUN;
                        count    <= reload_value(next_shadow);
                        tick_cnt <= '0;
                    end
                end
                RUN: begin
                    // The RUN step (decrement or tick+reload) is always
                    // completed, even on the edge that enters PAUSE or DONE.
                    if (at_zero) begin
                        tick  <= 1'b1;
                        count <= reload_value(next_shadow);
                        if (last_tick) begin
                            tick_cnt <= '0;
                            lv       <= lv + 1'b1;
`ifdef SC_LEVEL_TIMER_LVUP_EN
                            lvup     <= 1'b1;
`endif
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end else begin
                        count <= count - 1'b1;
                    end
                    if (at_zero && last_tick && last_level) begin
                        state <= DONE;
                    end else if (SC_LEVEL_TIMER_START_InLow) begin
                        state <= PAUSE;
                    end
                end
                PAUSE: begin
                    // Resume without decrementing: the frozen count continues.
                    if (!SC_LEVEL_TIMER_START_InLow) begin
                        state <= RUN;
                    end
                end
                DONE: begin
                end
            endcase
        end
    end

    assign SC_LEVEL_TIMER_TICK  = tick;
    assign SC_LEVEL_TIMER_LV    = lv;
    assign SC_LEVEL_TIMER_LVUP  = lvup;
    assign SC_LEVEL_TIMER_STATE = state;

endmodule
